// File: rtl/trig_pkg.sv
// ============================================================================
// trig_pkg : shared types and constants for the trigger capture block
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package trig_pkg;

   localparam int CNT_W_DEF    = 16;
   localparam int FILT_LEN_DEF = 4;

   // Saturation ceiling at the default counter width.
   localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      HIGH  = 2'd2,
      LOW   = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/trigger_capture_if.sv
// ============================================================================
// trigger_capture_if : arm/ack control and result handshake of trigger_capture
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

interface trigger_capture_if #(
   parameter int CNT_W = trig_pkg::CNT_W_DEF
);
   logic             Arm;
   logic             Ack;
   logic [CNT_W-1:0] Width_Out;
   logic [CNT_W-1:0] Period_Out;
   logic             Valid;
   logic             Overrun;
   logic             Busy;

   // master = consumer (drives Arm/Ack), slave = trigger_capture
   modport master (
      output Arm, Ack,
      input  Width_Out, Period_Out, Valid, Overrun, Busy
   );

   modport slave (
      input  Arm, Ack,
      output Width_Out, Period_Out, Valid, Overrun, Busy
   );
endinterface

`default_nettype wire

// File: rtl/trig_sync_edge.sv
// ============================================================================
// trig_sync_edge : 2-flop synchronizer, optional glitch filter (macro
//                  TRIG_GLITCH_FILTER_EN) and rise/fall pulse generation
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module trig_sync_edge #(
   parameter int FILT_LEN = trig_pkg::FILT_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise,
   output logic fall
);

   if (FILT_LEN < 1) begin : g_filt_len_check
      $error("trig_sync_edge: FILT_LEN must be at least 1");
   end

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s3_q, s3_d;
   logic level;

`ifdef TRIG_GLITCH_FILTER_EN
   localparam int FC_W = $clog2(FILT_LEN + 1);

   logic            filt_q, filt_d;
   logic [FC_W-1:0] fcnt_q, fcnt_d;

   // fcnt counts consecutive samples disagreeing with the filtered level;
   // the FILT_LEN-th such sample flips it.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (s2_q != filt_q) begin
         if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
            filt_d = s2_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign level = filt_q;
`else
   assign level = s2_q;
`endif

   always_comb begin
      s1_d = sig_in;
      s2_d = s1_q;
      s3_d = level;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise = level & ~s3_q;
   assign fall = ~level & s3_q;

endmodule

`default_nettype wire

// File: rtl/trigger_capture.sv
// ============================================================================
// trigger_capture : measures pulse width and period of an async trigger line
//                   and hands results over with Valid/Ack. Optional glitch
//                   filter enabled by macro TRIG_GLITCH_FILTER_EN.
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module trigger_capture
   import trig_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Sig_In,
   trigger_capture_if.slave  bus
);

   localparam logic [CNT_W-1:0] SAT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == SAT_MAX) ? v : v + 1'b1;
   endfunction

   logic rise, fall;

   trig_sync_edge #(
      .FILT_LEN (FILT_LEN)
   ) u_sync (
      .clk    (Clk),
      .rst    (Reset),
      .sig_in (Sig_In),
      .rise   (rise),
      .fall   (fall)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             busy_q, busy_d;
   logic             publish;

   // Measurement FSM and counters
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      pcnt_d  = pcnt_q;
      publish = 1'b0;

      unique case (state_q)
         IDLE: begin
            wcnt_d = '0;
            pcnt_d = '0;
            if (bus.Arm) state_d = ARMED;
         end
         ARMED: begin
            if (rise) begin
               state_d = HIGH;
               wcnt_d  = CNT_ONE;
               pcnt_d  = CNT_ONE;
            end
         end
         HIGH: begin
            pcnt_d = sat_inc(pcnt_q);
            if (fall) state_d = LOW;
            else      wcnt_d  = sat_inc(wcnt_q);
         end
         LOW: begin
            if (rise) begin
               publish = 1'b1;
               state_d = HIGH;
               wcnt_d  = CNT_ONE;
               pcnt_d  = CNT_ONE;
            end else begin
               pcnt_d = sat_inc(pcnt_q);
            end
         end
         default: state_d = IDLE;
      endcase

      // Disarming wins over everything, including a pending publish.
      if (!bus.Arm) begin
         state_d = IDLE;
         wcnt_d  = '0;
         pcnt_d  = '0;
         publish = 1'b0;
      end
   end

   // Result handshake
   always_comb begin
      width_d   = width_q;
      period_d  = period_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      busy_d    = (state_d != IDLE);

      if (publish) begin
         if (!valid_q || bus.Ack) begin
            width_d  = wcnt_q;
            period_d = pcnt_q;
            valid_d  = 1'b1;
            if (valid_q) overrun_d = 1'b0;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (bus.Ack && valid_q) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         wcnt_q    <= '0;
         pcnt_q    <= '0;
         width_q   <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         pcnt_q    <= pcnt_d;
         width_q   <= width_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.Width_Out  = width_q;
   assign bus.Period_Out = period_q;
   assign bus.Valid      = valid_q;
   assign bus.Overrun    = overrun_q;
   assign bus.Busy       = busy_q;

endmodule

`default_nettype wire
